// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between two writeback sources:
// A (ALU result path) and B (load return path). Each source has a one-entry
// holding register behind a valid/ready handshake. A round-robin grant drains
// at most one holding register per cycle onto the registered write port.
// A pending mask marks destination registers whose write is still in flight,
// for use by hazard/stall logic.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous, active-high reset
//   flush_i      synchronous discard of all queued and in-flight writes
//   a_valid_i    source A write request
//   a_ready_o    source A can be accepted this cycle
//   a_addr_i     source A destination register
//   a_data_i     source A write data
//   b_valid_i    source B write request
//   b_ready_o    source B can be accepted this cycle
//   b_addr_i     source B destination register
//   b_data_i     source B write data
//   we3_o        regfile write enable (registered)
//   addr3_o      regfile write address (registered)
//   wd3_o        regfile write data (registered)
//   pending_o    bit r set while a write to r is held or on the write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          a_valid_i,
  output logic                          a_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]      a_addr_i,
  input  logic [DATA_WIDTH-1:0]         a_data_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]      b_addr_i,
  input  logic [DATA_WIDTH-1:0]         b_data_i,
  output logic                          we3_o,
  output logic [ADDRESS_WIDTH-1:0]      addr3_o,
  output logic [DATA_WIDTH-1:0]         wd3_o,
  output logic [(2**ADDRESS_WIDTH)-1:0] pending_o
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Holding registers
  logic                     hold_v_a_q, hold_v_a_d;
  logic [ADDRESS_WIDTH-1:0] hold_addr_a_q, hold_addr_a_d;
  logic [DATA_WIDTH-1:0]    hold_data_a_q, hold_data_a_d;
  logic                     hold_v_b_q, hold_v_b_d;
  logic [ADDRESS_WIDTH-1:0] hold_addr_b_q, hold_addr_b_d;
  logic [DATA_WIDTH-1:0]    hold_data_b_q, hold_data_b_d;

  // Arbitration and write port
  src_e                     last_gnt_q, last_gnt_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] addr3_q, addr3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  logic gnt_a, gnt_b;
  logic acc_a, acc_b;

  // Round-robin: a source wins if it is alone, or if it did not win last.
  assign gnt_a = hold_v_a_q && (!hold_v_b_q || (last_gnt_q != SRC_A));
  assign gnt_b = hold_v_b_q && (!hold_v_a_q || (last_gnt_q != SRC_B));

  // A full holding register can still accept when it drains on the same edge,
  // which is what lets a lone source sustain one write per cycle.
  assign a_ready_o = !rst_i && !flush_i && (!hold_v_a_q || gnt_a);
  assign b_ready_o = !rst_i && !flush_i && (!hold_v_b_q || gnt_b);

  assign acc_a = a_valid_i && a_ready_o;
  assign acc_b = b_valid_i && b_ready_o;

  always_comb begin
    hold_v_a_d    = hold_v_a_q;
    hold_addr_a_d = hold_addr_a_q;
    hold_data_a_d = hold_data_a_q;
    hold_v_b_d    = hold_v_b_q;
    hold_addr_b_d = hold_addr_b_q;
    hold_data_b_d = hold_data_b_q;
    last_gnt_d    = last_gnt_q;
    we3_d         = 1'b0;
    addr3_d       = addr3_q;
    wd3_d         = wd3_q;

    if (flush_i) begin
      // Everything in flight is dropped; the arbitration history is kept.
      hold_v_a_d = 1'b0;
      hold_v_b_d = 1'b0;
    end else begin
      // Drain
      if (gnt_a) begin
        we3_d      = 1'b1;
        addr3_d    = hold_addr_a_q;
        wd3_d      = hold_data_a_q;
        last_gnt_d = SRC_A;
        hold_v_a_d = 1'b0;
      end else if (gnt_b) begin
        we3_d      = 1'b1;
        addr3_d    = hold_addr_b_q;
        wd3_d      = hold_data_b_q;
        last_gnt_d = SRC_B;
        hold_v_b_d = 1'b0;
      end

      // Accept (a same-edge accept refills a register that just drained).
      // Writes to x0 complete the handshake but are never stored.
      if (acc_a) begin
        hold_v_a_d    = (a_addr_i != '0);
        hold_addr_a_d = a_addr_i;
        hold_data_a_d = a_data_i;
      end
      if (acc_b) begin
        hold_v_b_d    = (b_addr_i != '0);
        hold_addr_b_d = b_addr_i;
        hold_data_b_d = b_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_v_a_q    <= 1'b0;
      hold_addr_a_q <= '0;
      hold_data_a_q <= '0;
      hold_v_b_q    <= 1'b0;
      hold_addr_b_q <= '0;
      hold_data_b_q <= '0;
      last_gnt_q    <= SRC_B;
      we3_q         <= 1'b0;
      addr3_q       <= '0;
      wd3_q         <= '0;
    end else begin
      hold_v_a_q    <= hold_v_a_d;
      hold_addr_a_q <= hold_addr_a_d;
      hold_data_a_q <= hold_data_a_d;
      hold_v_b_q    <= hold_v_b_d;
      hold_addr_b_q <= hold_addr_b_d;
      hold_data_b_q <= hold_data_b_d;
      last_gnt_q    <= last_gnt_d;
      we3_q         <= we3_d;
      addr3_q       <= addr3_d;
      wd3_q         <= wd3_d;
    end
  end

  assign we3_o   = we3_q;
  assign addr3_o = addr3_q;
  assign wd3_o   = wd3_q;

  // Register 0 is hardwired, so it is never reported as pending.
  always_comb begin
    pending_o = '0;
    for (int r = 1; r < NREG; r++) begin
      pending_o[r] = (hold_v_a_q && (hold_addr_a_q == ADDRESS_WIDTH'(r))) ||
                     (hold_v_b_q && (hold_addr_b_q == ADDRESS_WIDTH'(r))) ||
                     (we3_q      && (addr3_q       == ADDRESS_WIDTH'(r)));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        a_valid_i, b_valid_i;
  logic        a_ready_o, b_ready_o;
  logic [4:0]  a_addr_i, b_addr_i;
  logic [31:0] a_data_i, b_data_i;
  logic        we3_o;
  logic [4:0]  addr3_o;
  logic [31:0] wd3_o;
  logic [31:0] pending_o;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .a_valid_i (a_valid_i),
    .a_ready_o (a_ready_o),
    .a_addr_i  (a_addr_i),
    .a_data_i  (a_data_i),
    .b_valid_i (b_valid_i),
    .b_ready_o (b_ready_o),
    .b_addr_i  (b_addr_i),
    .b_data_i  (b_data_i),
    .we3_o     (we3_o),
    .addr3_o   (addr3_o),
    .wd3_o     (wd3_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    a_valid_i = v; a_addr_i = ad; a_data_i = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    b_valid_i = v; b_addr_i = ad; b_data_i = d;
  endtask

  task automatic expect_wr(input logic [4:0] ad, input logic [31:0] d);
    wr_t w;
    w.addr = ad;
    w.data = d;
    sb.push_back(w);
  endtask

  // Monitor: every regfile write must match the next expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_i);
      if (!rst_i && we3_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", {59'd0, addr3_o}, 64'hFFFF);
        end else begin
          w = sb.pop_front();
          chk("wr_addr", {59'd0, addr3_o}, {59'd0, w.addr});
          chk("wr_data", {32'd0, wd3_o}, {32'd0, w.data});
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    drive_a(0, 5'd0, 32'd0);
    drive_b(0, 5'd0, 32'd0);

    // Reset
    step(); step();
    chk("rst_we3",     {63'd0, we3_o}, 64'd0);
    chk("rst_addr3",   {59'd0, addr3_o}, 64'd0);
    chk("rst_wd3",     {32'd0, wd3_o}, 64'd0);
    chk("rst_pending", {32'd0, pending_o}, 64'd0);
    chk("rst_a_ready", {63'd0, a_ready_o}, 64'd0);
    chk("rst_b_ready", {63'd0, b_ready_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rel_a_ready", {63'd0, a_ready_o}, 64'd1);
    chk("rel_b_ready", {63'd0, b_ready_o}, 64'd1);

    // A alone, back to back
    drive_a(1, 5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
    step();
    chk("a_pend_after_acc", {32'd0, pending_o}, 64'h20);
    chk("a_we3_latency",    {63'd0, we3_o}, 64'd0);
    drive_a(1, 5'd6, 32'h12345678); expect_wr(5'd6, 32'h12345678);
    step();
    chk("a_we3_k1",  {63'd0, we3_o}, 64'd1);
    chk("a_pend_k1", {32'd0, pending_o}, 64'h60);
    drive_a(1, 5'd5, 32'hCAFEF00D); expect_wr(5'd5, 32'hCAFEF00D);
    step();
    chk("a_we3_k2", {63'd0, we3_o}, 64'd1);
    drive_a(0, 5'd0, 32'd0);
    step();
    chk("a_we3_k3", {63'd0, we3_o}, 64'd1);
    step();
    chk("a_we3_idle",  {63'd0, we3_o}, 64'd0);
    chk("a_pend_idle", {32'd0, pending_o}, 64'd0);

    // B alone (leaves last grant on B)
    drive_b(1, 5'd9, 32'h55); expect_wr(5'd9, 32'h55);
    step();
    drive_b(0, 5'd0, 32'd0);
    step(); step();

    // x0 write: handshake completes, nothing written
    drive_a(1, 5'd0, 32'h99);
    #1;
    chk("x0_a_ready", {63'd0, a_ready_o}, 64'd1);
    step();
    drive_a(0, 5'd0, 32'd0);
    chk("x0_pending", {32'd0, pending_o}, 64'd0);
    step();
    chk("x0_we3_1", {63'd0, we3_o}, 64'd0);
    step();
    chk("x0_we3_2", {63'd0, we3_o}, 64'd0);

    // Contention: A then B alternating
    drive_a(1, 5'd3, 32'h11); drive_b(1, 5'd4, 32'h22);
    expect_wr(5'd3, 32'h11); expect_wr(5'd4, 32'h22);
    expect_wr(5'd3, 32'h33); expect_wr(5'd4, 32'h44);
    step();
    chk("ct_a_ready_0", {63'd0, a_ready_o}, 64'd1);
    chk("ct_b_ready_0", {63'd0, b_ready_o}, 64'd0);
    drive_a(1, 5'd3, 32'h33); drive_b(1, 5'd4, 32'h44);
    step();
    chk("ct_a_ready_1", {63'd0, a_ready_o}, 64'd0);
    chk("ct_b_ready_1", {63'd0, b_ready_o}, 64'd1);
    drive_a(0, 5'd0, 32'd0);
    step();
    chk("ct_b_ready_2", {63'd0, b_ready_o}, 64'd0);
    drive_b(0, 5'd0, 32'd0);
    step(); step(); step();
    chk("ct_we3_idle", {63'd0, we3_o}, 64'd0);

    // Same rd from both sources, last grant was B so A goes first
    drive_a(1, 5'd7, 32'h1); drive_b(1, 5'd7, 32'h2);
    expect_wr(5'd7, 32'h1); expect_wr(5'd7, 32'h2);
    step();
    chk("same_rd_pend", {32'd0, pending_o}, 64'h80);
    drive_a(0, 5'd0, 32'd0); drive_b(0, 5'd0, 32'd0);
    step(); step(); step();

    // Flush with both holds full and a write on the port
    drive_a(1, 5'd10, 32'hA0); drive_b(1, 5'd11, 32'hB0);
    expect_wr(5'd10, 32'hA0);
    step();
    drive_a(1, 5'd12, 32'hA1); drive_b(0, 5'd0, 32'd0);
    step();
    chk("fl_we3_before", {63'd0, we3_o}, 64'd1);
    chk("fl_pend_before", {32'd0, pending_o}, 64'h1C00);
    drive_a(0, 5'd0, 32'd0);
    flush_i = 1'b1;
    #1;
    chk("fl_a_ready", {63'd0, a_ready_o}, 64'd0);
    chk("fl_b_ready", {63'd0, b_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
    chk("fl_we3_after",  {63'd0, we3_o}, 64'd0);
    chk("fl_pend_after", {32'd0, pending_o}, 64'd0);
    // Last grant (A) survives the flush, so B wins the next tie
    drive_a(1, 5'd13, 32'h13); drive_b(1, 5'd14, 32'h14);
    expect_wr(5'd14, 32'h14); expect_wr(5'd13, 32'h13);
    step();
    drive_a(0, 5'd0, 32'd0); drive_b(0, 5'd0, 32'd0);
    step(); step(); step();

    // Reset mid-operation drops the held write
    drive_a(1, 5'd15, 32'hF);
    step();
    drive_a(0, 5'd0, 32'd0);
    #1 rst_i = 1'b1;
    #1;
    chk("mr_pending", {32'd0, pending_o}, 64'd0);
    chk("mr_we3",     {63'd0, we3_o}, 64'd0);
    chk("mr_a_ready", {63'd0, a_ready_o}, 64'd0);
    chk("mr_b_ready", {63'd0, b_ready_o}, 64'd0);
    step();
    rst_i = 1'b0;
    step(); step();
    chk("mr_we3_after", {63'd0, we3_o}, 64'd0);

    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
